// File: rtl/wb_result_drain_if.sv
// Execute-to-writeback result bus plus the register, segment and memory write ports
// that the drain unit drives. The master modport is the execute/store side.
interface wb_result_drain_if #(
  parameter int DW = 64
);
  logic              valid_in;
  logic [31:0]       EIP_in;
  logic [1:0]        ressize;
  logic [3:0]        res_wb;
  logic [4*DW-1:0]   res_data;
  logic [127:0]      res_dest;
  logic [3:0]        res_is_reg;
  logic [3:0]        res_is_seg;
  logic [3:0]        res_is_mem;
  logic              stall;

  logic              reg_we;
  logic [31:0]       reg_addr;
  logic [DW-1:0]     reg_wdata;
  logic [1:0]        reg_size;

  logic              seg_we;
  logic [31:0]       seg_addr;
  logic [15:0]       seg_wdata;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [31:0]       mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [1:0]        mem_size;

  logic              retire_valid;
  logic [31:0]       retire_EIP;

  modport master (
    output valid_in, EIP_in, ressize, res_wb, res_data, res_dest,
           res_is_reg, res_is_seg, res_is_mem, mem_req_ready,
    input  stall, reg_we, reg_addr, reg_wdata, reg_size,
           seg_we, seg_addr, seg_wdata,
           mem_req_valid, mem_addr, mem_wdata, mem_size,
           retire_valid, retire_EIP
  );

  modport slave (
    input  valid_in, EIP_in, ressize, res_wb, res_data, res_dest,
           res_is_reg, res_is_seg, res_is_mem, mem_req_ready,
    output stall, reg_we, reg_addr, reg_wdata, reg_size,
           seg_we, seg_addr, seg_wdata,
           mem_req_valid, mem_addr, mem_wdata, mem_size,
           retire_valid, retire_EIP
  );
endinterface

// File: rtl/wb_result_drain.sv
// Buffers execute results per instruction and drains them one write per cycle,
// in slot order, to the register, segment and memory ports, then retires the EIP.
module wb_result_drain #(
  parameter int DEPTH = 2,
  parameter int DW    = 64
) (
  input  logic             clk,
  input  logic             rst,
  wb_result_drain_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, DRAIN, MEMWAIT} state_e;

  typedef struct packed {
    logic [31:0]          eip;
    logic [1:0]           size;
    logic [3:0]           pend;
    logic [3:0]           is_reg;
    logic [3:0]           is_seg;
    logic [3:0]           is_mem;
    logic [3:0][31:0]     dest;
    logic [3:0][DW-1:0]   data;
  } entry_t;

  state_e        state_q, state_d;
  entry_t        fifo_q [DEPTH];
  entry_t        fifo_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  entry_t        head;
  logic [1:0]    cur;
  logic          found;
  logic          stall, enq, pop, done;
  logic [3:0]    clr;
  logic          reg_we, seg_we, mem_v;

  assign head  = fifo_q[head_q];
  assign stall = (count_q == FULL);
  assign enq   = bus.valid_in && !stall;

  always_comb begin
    cur   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && head.pend[i]) begin
        cur   = 2'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    fifo_d  = fifo_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    reg_we  = 1'b0;
    seg_we  = 1'b0;
    mem_v   = 1'b0;
    done    = 1'b0;
    pop     = 1'b0;
    clr     = 4'b0;

    if (state_q != IDLE) begin
      if (!found) begin
        pop = 1'b1;
      end else if (head.is_mem[cur]) begin
        mem_v = 1'b1;
        if (bus.mem_req_ready) done = 1'b1;
        else                   state_d = MEMWAIT;
      end else if (head.is_reg[cur]) begin
        reg_we = 1'b1;
        done   = 1'b1;
      end else if (head.is_seg[cur]) begin
        seg_we = 1'b1;
        done   = 1'b1;
      end else begin
        done = 1'b1;
      end

      if (done) begin
        clr = 4'b0001 << cur;
        if ((head.pend & ~clr) == 4'b0) pop = 1'b1;
        else                            state_d = DRAIN;
      end
    end

    if (clr != 4'b0) fifo_d[head_q].pend = head.pend & ~clr;
    if (pop) head_d = head_q + PTR_ONE;

    if (enq) begin
      fifo_d[tail_q] = '{eip:    bus.EIP_in,
                         size:   bus.ressize,
                         pend:   bus.res_wb,
                         is_reg: bus.res_is_reg,
                         is_seg: bus.res_is_seg,
                         is_mem: bus.res_is_mem,
                         dest:   bus.res_dest,
                         data:   bus.res_data};
      tail_d = tail_q + PTR_ONE;
    end

    if (enq && !pop)      count_d = count_q + CNT_ONE;
    else if (!enq && pop) count_d = count_q - CNT_ONE;

    // Leaving IDLE on the enqueue edge lets the first write issue one cycle later.
    if (pop || state_q == IDLE) state_d = (count_d != '0) ? DRAIN : IDLE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is not reset; count/state gate every use, so stale contents are never observed.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign bus.stall         = stall;
  assign bus.reg_we        = reg_we;
  assign bus.reg_addr      = reg_we ? head.dest[cur] : '0;
  assign bus.reg_wdata     = reg_we ? head.data[cur] : '0;
  assign bus.reg_size      = reg_we ? head.size : '0;
  assign bus.seg_we        = seg_we;
  assign bus.seg_addr      = seg_we ? head.dest[cur] : '0;
  assign bus.seg_wdata     = seg_we ? head.data[cur][15:0] : '0;
  assign bus.mem_req_valid = mem_v;
  assign bus.mem_addr      = mem_v ? head.dest[cur] : '0;
  assign bus.mem_wdata     = mem_v ? head.data[cur] : '0;
  assign bus.mem_size      = mem_v ? head.size : '0;
  assign bus.retire_valid  = pop;
  assign bus.retire_EIP    = pop ? head.eip : '0;

endmodule

// File: tb/tb_wb_result_drain.sv
// Directed bench for wb_result_drain: slot ordering, memory back-pressure,
// FIFO stall, empty entries, flag priority and reset during MEMWAIT.
module tb_wb_result_drain;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_result_drain_if #(.DW(64)) bus ();

  wb_result_drain #(.DEPTH(2), .DW(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.valid_in   = 1'b0;
    bus.EIP_in     = '0;
    bus.ressize    = '0;
    bus.res_wb     = '0;
    bus.res_data   = '0;
    bus.res_dest   = '0;
    bus.res_is_reg = '0;
    bus.res_is_seg = '0;
    bus.res_is_mem = '0;
  endtask

  task automatic load_slot(input int n, input logic [2:0] flags_rsm,
                           input logic [31:0] dest, input logic [63:0] data);
    bus.res_wb[n-1]            = 1'b1;
    bus.res_is_reg[n-1]        = flags_rsm[2];
    bus.res_is_seg[n-1]        = flags_rsm[1];
    bus.res_is_mem[n-1]        = flags_rsm[0];
    bus.res_dest[n*32-1 -: 32] = dest;
    bus.res_data[n*64-1 -: 64] = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.mem_req_ready = 1'b0;
    tick();
    tick();
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0h exp 0", bus.stall); end
    checks++; if ({bus.reg_we, bus.seg_we, bus.mem_req_valid, bus.retire_valid} !== 4'b0) begin
      errors++; $display("FAIL rst_strobes: got %b exp 0000", {bus.reg_we, bus.seg_we, bus.mem_req_valid, bus.retire_valid}); end
    checks++; if ({bus.reg_addr, bus.seg_addr, bus.mem_addr, bus.retire_EIP} !== 128'b0) begin
      errors++; $display("FAIL rst_addr: got %h exp 0", {bus.reg_addr, bus.seg_addr, bus.mem_addr, bus.retire_EIP}); end
    checks++; if ({bus.reg_wdata, bus.mem_wdata, bus.seg_wdata} !== 144'b0) begin
      errors++; $display("FAIL rst_data: got %h exp 0", {bus.reg_wdata, bus.mem_wdata, bus.seg_wdata}); end
    rst = 1'b0;
  endtask

  task automatic test_reg_seg();
    bus.valid_in = 1'b1;
    bus.EIP_in   = 32'h100;
    bus.ressize  = 2'd2;
    load_slot(1, 3'b100, 32'h3, 64'h55);
    load_slot(2, 3'b010, 32'h2, 64'h1234);
    tick();
    clear_inputs();
    checks++; if (bus.reg_we !== 1'b1) begin errors++; $display("FAIL rs_reg_we: got %0h exp 1", bus.reg_we); end
    checks++; if (bus.reg_addr !== 32'h3) begin errors++; $display("FAIL rs_reg_addr: got %h exp 3", bus.reg_addr); end
    checks++; if (bus.reg_wdata !== 64'h55) begin errors++; $display("FAIL rs_reg_wdata: got %h exp 55", bus.reg_wdata); end
    checks++; if (bus.reg_size !== 2'd2) begin errors++; $display("FAIL rs_reg_size: got %0d exp 2", bus.reg_size); end
    checks++; if ({bus.seg_we, bus.retire_valid} !== 2'b00) begin errors++; $display("FAIL rs_c1_quiet: got %b exp 00", {bus.seg_we, bus.retire_valid}); end
    tick();
    checks++; if ({bus.seg_we, bus.reg_we} !== 2'b10) begin errors++; $display("FAIL rs_seg_we: got %b exp 10", {bus.seg_we, bus.reg_we}); end
    checks++; if (bus.seg_addr !== 32'h2) begin errors++; $display("FAIL rs_seg_addr: got %h exp 2", bus.seg_addr); end
    checks++; if (bus.seg_wdata !== 16'h1234) begin errors++; $display("FAIL rs_seg_wdata: got %h exp 1234", bus.seg_wdata); end
    checks++; if (bus.retire_valid !== 1'b1) begin errors++; $display("FAIL rs_retire: got %0h exp 1", bus.retire_valid); end
    checks++; if (bus.retire_EIP !== 32'h100) begin errors++; $display("FAIL rs_retire_eip: got %h exp 100", bus.retire_EIP); end
    tick();
    checks++; if ({bus.seg_we, bus.reg_we, bus.retire_valid} !== 3'b0) begin
      errors++; $display("FAIL rs_after: got %b exp 000", {bus.seg_we, bus.reg_we, bus.retire_valid}); end
  endtask

  task automatic test_mem_wait();
    bus.valid_in      = 1'b1;
    bus.EIP_in        = 32'h200;
    bus.ressize       = 2'd3;
    bus.mem_req_ready = 1'b0;
    load_slot(3, 3'b001, 32'h1000, 64'hDEADBEEF);
    tick();
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL mw_valid_c%0d: got %0h exp 1", c, bus.mem_req_valid); end
      checks++; if (bus.mem_addr !== 32'h1000) begin errors++; $display("FAIL mw_addr_c%0d: got %h exp 1000", c, bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 64'hDEADBEEF) begin errors++; $display("FAIL mw_wdata_c%0d: got %h exp deadbeef", c, bus.mem_wdata); end
      checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL mw_noretire_c%0d: got %0h exp 0", c, bus.retire_valid); end
      tick();
    end
    bus.mem_req_ready = 1'b1;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL mw_valid_rdy: got %0h exp 1", bus.mem_req_valid); end
    checks++; if (bus.mem_addr !== 32'h1000) begin errors++; $display("FAIL mw_addr_rdy: got %h exp 1000", bus.mem_addr); end
    checks++; if (bus.mem_size !== 2'd3) begin errors++; $display("FAIL mw_size: got %0d exp 3", bus.mem_size); end
    checks++; if (bus.retire_valid !== 1'b1) begin errors++; $display("FAIL mw_retire: got %0h exp 1", bus.retire_valid); end
    checks++; if (bus.retire_EIP !== 32'h200) begin errors++; $display("FAIL mw_retire_eip: got %h exp 200", bus.retire_EIP); end
    tick();
    bus.mem_req_ready = 1'b0;
    #1;
    checks++; if ({bus.mem_req_valid, bus.retire_valid} !== 2'b00) begin
      errors++; $display("FAIL mw_after: got %b exp 00", {bus.mem_req_valid, bus.retire_valid}); end
  endtask

  task automatic test_back_to_back();
    int          vin_idx   [8] = '{0, 1, 2, 2, -1, -1, -1, -1};
    logic        exp_stall [8] = '{0, 0, 1, 0, 1, 0, 0, 0};
    logic        exp_we    [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic [31:0] exp_addr  [8] = '{32'h0, 32'h10, 32'h20, 32'h11, 32'h21, 32'h12, 32'h22, 32'h0};
    logic        exp_ret   [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
    logic [31:0] exp_eip   [8] = '{32'h0, 32'h0, 32'h500, 32'h0, 32'h501, 32'h0, 32'h502, 32'h0};
    for (int k = 0; k < 8; k++) begin
      clear_inputs();
      if (vin_idx[k] >= 0) begin
        bus.valid_in = 1'b1;
        bus.EIP_in   = 32'h500 + 32'(vin_idx[k]);
        load_slot(1, 3'b100, 32'h10 + 32'(vin_idx[k]), 64'hA0 + 64'(vin_idx[k]));
        load_slot(2, 3'b100, 32'h20 + 32'(vin_idx[k]), 64'hB0 + 64'(vin_idx[k]));
      end
      #1;
      checks++; if (bus.stall !== exp_stall[k]) begin errors++; $display("FAIL b2b_stall_k%0d: got %0h exp %0h", k, bus.stall, exp_stall[k]); end
      checks++; if (bus.reg_we !== exp_we[k]) begin errors++; $display("FAIL b2b_we_k%0d: got %0h exp %0h", k, bus.reg_we, exp_we[k]); end
      checks++; if (bus.reg_addr !== exp_addr[k]) begin errors++; $display("FAIL b2b_addr_k%0d: got %h exp %h", k, bus.reg_addr, exp_addr[k]); end
      checks++; if (bus.retire_valid !== exp_ret[k]) begin errors++; $display("FAIL b2b_ret_k%0d: got %0h exp %0h", k, bus.retire_valid, exp_ret[k]); end
      checks++; if (bus.retire_EIP !== exp_eip[k]) begin errors++; $display("FAIL b2b_eip_k%0d: got %h exp %h", k, bus.retire_EIP, exp_eip[k]); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_empty_entry();
    bus.valid_in   = 1'b1;
    bus.EIP_in     = 32'h300;
    bus.res_is_reg = 4'hF;
    bus.res_is_mem = 4'hF;
    tick();
    clear_inputs();
    checks++; if ({bus.reg_we, bus.seg_we, bus.mem_req_valid} !== 3'b0) begin
      errors++; $display("FAIL empty_strobes: got %b exp 000", {bus.reg_we, bus.seg_we, bus.mem_req_valid}); end
    checks++; if (bus.retire_valid !== 1'b1) begin errors++; $display("FAIL empty_retire: got %0h exp 1", bus.retire_valid); end
    checks++; if (bus.retire_EIP !== 32'h300) begin errors++; $display("FAIL empty_eip: got %h exp 300", bus.retire_EIP); end
    tick();
    checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL empty_after: got %0h exp 0", bus.retire_valid); end
  endtask

  task automatic test_flag_priority();
    bus.valid_in      = 1'b1;
    bus.EIP_in        = 32'h400;
    bus.mem_req_ready = 1'b1;
    load_slot(1, 3'b101, 32'h44, 64'h77);
    load_slot(2, 3'b000, 32'h66, 64'h88);
    load_slot(3, 3'b100, 32'h9, 64'h99);
    tick();
    clear_inputs();
    checks++; if ({bus.mem_req_valid, bus.reg_we} !== 2'b10) begin
      errors++; $display("FAIL prio_mem_only: got %b exp 10", {bus.mem_req_valid, bus.reg_we}); end
    checks++; if (bus.mem_addr !== 32'h44) begin errors++; $display("FAIL prio_mem_addr: got %h exp 44", bus.mem_addr); end
    checks++; if (bus.retire_valid !== 1'b0) begin errors++; $display("FAIL prio_c1_ret: got %0h exp 0", bus.retire_valid); end
    tick();
    checks++; if ({bus.mem_req_valid, bus.reg_we, bus.seg_we, bus.retire_valid} !== 4'b0) begin
      errors++; $display("FAIL prio_noflag: got %b exp 0000", {bus.mem_req_valid, bus.reg_we, bus.seg_we, bus.retire_valid}); end
    tick();
    checks++; if (bus.reg_we !== 1'b1 || bus.reg_addr !== 32'h9) begin
      errors++; $display("FAIL prio_reg: got we=%0h addr=%h exp we=1 addr=9", bus.reg_we, bus.reg_addr); end
    checks++; if (bus.retire_valid !== 1'b1 || bus.retire_EIP !== 32'h400) begin
      errors++; $display("FAIL prio_retire: got %0h/%h exp 1/400", bus.retire_valid, bus.retire_EIP); end
    tick();
    bus.mem_req_ready = 1'b0;
  endtask

  task automatic test_reset_memwait();
    bus.mem_req_ready = 1'b0;
    bus.valid_in      = 1'b1;
    bus.EIP_in        = 32'h600;
    load_slot(1, 3'b001, 32'h2000, 64'h1);
    tick();
    clear_inputs();
    bus.valid_in = 1'b1;
    bus.EIP_in   = 32'h601;
    load_slot(1, 3'b100, 32'h7, 64'h2);
    tick();
    clear_inputs();
    checks++; if (bus.stall !== 1'b1 || bus.mem_req_valid !== 1'b1) begin
      errors++; $display("FAIL rmw_pre: got stall=%0h mv=%0h exp 1/1", bus.stall, bus.mem_req_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.stall, bus.mem_req_valid, bus.reg_we, bus.seg_we, bus.retire_valid} !== 5'b0) begin
      errors++; $display("FAIL rmw_idle: got %b exp 00000", {bus.stall, bus.mem_req_valid, bus.reg_we, bus.seg_we, bus.retire_valid}); end
    checks++; if ({bus.mem_addr, bus.retire_EIP} !== 64'b0) begin
      errors++; $display("FAIL rmw_addr: got %h exp 0", {bus.mem_addr, bus.retire_EIP}); end
    tick();
    checks++; if ({bus.mem_req_valid, bus.reg_we, bus.retire_valid} !== 3'b0) begin
      errors++; $display("FAIL rmw_discard: got %b exp 000", {bus.mem_req_valid, bus.reg_we, bus.retire_valid}); end
    bus.valid_in = 1'b1;
    bus.EIP_in   = 32'h700;
    load_slot(1, 3'b100, 32'h5, 64'h99);
    tick();
    clear_inputs();
    checks++; if (bus.reg_we !== 1'b1 || bus.reg_addr !== 32'h5 || bus.reg_wdata !== 64'h99) begin
      errors++; $display("FAIL rmw_fresh_reg: got %0h/%h/%h exp 1/5/99", bus.reg_we, bus.reg_addr, bus.reg_wdata); end
    checks++; if (bus.retire_valid !== 1'b1 || bus.retire_EIP !== 32'h700) begin
      errors++; $display("FAIL rmw_fresh_ret: got %0h/%h exp 1/700", bus.retire_valid, bus.retire_EIP); end
    tick();
    checks++; if ({bus.reg_we, bus.retire_valid} !== 2'b00) begin
      errors++; $display("FAIL rmw_fresh_after: got %b exp 00", {bus.reg_we, bus.retire_valid}); end
  endtask

  initial begin
    test_reset();
    test_reg_seg();
    test_mem_wait();
    test_back_to_back();
    test_empty_entry();
    test_flag_priority();
    test_reset_memwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
